// File: rtl/gray_seq_ctrl.sv
// Command-driven binary counter sequencer with a registered Gray-coded valid/ready output.
// Optional step checker enabled by defining GRAY_SEQ_CHECK_EN.
module gray_seq_ctrl #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [DATA_WIDTH-1:0] cmd_start,
   input  logic [DATA_WIDTH-1:0] cmd_count,
   input  logic                  cmd_dir,
   input  logic                  abort,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [DATA_WIDTH-1:0] BIN_ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] BIN_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH:0]   CNT_ONE  = {{DATA_WIDTH{1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH:0]   CNT_TWO  = {{(DATA_WIDTH-1){1'b0}}, 2'b10};
   localparam logic [DATA_WIDTH:0]   CNT_FULL = {1'b1, {DATA_WIDTH{1'b0}}};

   function automatic logic [DATA_WIDTH-1:0] gray_enc(input logic [DATA_WIDTH-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_bin;
   logic [DATA_WIDTH:0]   r_remaining;
   logic                  r_dir;

   logic                  w_hs;
   logic                  w_accept;
   logic [DATA_WIDTH-1:0] w_bin_nxt;
   logic [DATA_WIDTH:0]   w_cnt_load;

   assign w_hs       = out_valid & out_ready;
   assign w_accept   = (r_state == ST_IDLE) & cmd_valid;
   assign w_bin_nxt  = r_dir ? (r_bin + BIN_ONE) : (r_bin - BIN_ONE);
   // A zero count requests one full lap of the code space.
   assign w_cnt_load = (cmd_count == BIN_ZERO) ? CNT_FULL : {1'b0, cmd_count};
   assign cmd_ready  = (r_state == ST_IDLE);

   // Sequencer FSM: command capture, stepping on handshake, termination and abort.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_bin       <= BIN_ZERO;
         r_remaining <= {(DATA_WIDTH+1){1'b0}};
         r_dir       <= 1'b0;
         out         <= BIN_ZERO;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_state     <= ST_RUN;
                  r_dir       <= cmd_dir;
                  r_bin       <= cmd_start;
                  r_remaining <= w_cnt_load;
                  out         <= gray_enc(cmd_start);
                  out_valid   <= 1'b1;
                  out_last    <= (w_cnt_load == CNT_ONE);
                  busy        <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               // Abort wins even over a simultaneous final handshake: no done pulse.
               if (abort) begin
                  r_state   <= ST_IDLE;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
               end else if (w_hs && out_last) begin
                  r_state   <= ST_IDLE;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else if (w_hs) begin
                  r_bin       <= w_bin_nxt;
                  r_remaining <= r_remaining - CNT_ONE;
                  out         <= gray_enc(w_bin_nxt);
                  out_last    <= (r_remaining == CNT_TWO);
               end else begin
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef GRAY_SEQ_CHECK_EN
   function automatic logic is_onehot(input logic [DATA_WIDTH-1:0] v);
      return (v != BIN_ZERO) && ((v & (v - BIN_ONE)) == BIN_ZERO);
   endfunction

   logic [DATA_WIDTH-1:0] r_prev;
   logic                  r_chk_pend;
   logic                  r_err;

   // Step checker: the code following each non-final handshake must differ in one bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev     <= BIN_ZERO;
         r_chk_pend <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_accept) begin
         r_chk_pend <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_chk_pend <= (r_state == ST_RUN) & ~abort & w_hs & ~out_last;
         if (w_hs) begin
            r_prev <= out;
         end else begin
            r_prev <= r_prev;
         end
         if (r_chk_pend && !is_onehot(out ^ r_prev)) begin
            r_err <= 1'b1;
         end else begin
            r_err <= r_err;
         end
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed self-checking bench for gray_seq_ctrl (DATA_WIDTH = 4).
module tb_gray_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_start;
   logic [3:0] cmd_count;
   logic       cmd_dir;
   logic       abort;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_code;
   logic       out_last;
   logic       busy;
   logic       done;
   logic       err;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   gray_seq_ctrl #(.DATA_WIDTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_start (cmd_start),
      .cmd_count (cmd_count),
      .cmd_dir   (cmd_dir),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out_code),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge with the DUT idle; returns on the falling edge of T+1.
   task automatic send_cmd(input logic [3:0] s, input logic [3:0] c, input logic d);
      cmd_valid = 1'b1;
      cmd_start = s;
      cmd_count = c;
      cmd_dir   = d;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Streams out the queued expected codes with out_ready high, then checks the done pulse.
   task automatic drain(input string tag);
      int         n;
      logic [3:0] e;
      n         = exp_q.size();
      e         = 4'h0;
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         check_val({tag, "_out"},   32'(out_code),  32'(e));
         check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
         check_val({tag, "_last"},  32'(out_last),  (i == n - 1) ? 32'd1 : 32'd0);
         check_val({tag, "_rdy"},   32'(cmd_ready), 32'd0);
         @(negedge clk);
      end
      check_val({tag, "_done"},     32'(done),      32'd1);
      check_val({tag, "_vld_end"},  32'(out_valid), 32'd0);
      check_val({tag, "_busy_end"}, 32'(busy),      32'd0);
      check_val({tag, "_rdy_end"},  32'(cmd_ready), 32'd1);
      check_val({tag, "_out_hold"}, 32'(out_code),  32'(e));
      @(negedge clk);
      check_val({tag, "_done_1cyc"}, 32'(done), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_start = 4'h0;
      cmd_count = 4'h0;
      cmd_dir   = 1'b1;
      abort     = 1'b0;
      out_ready = 1'b1;

      // 1: reset state
      #1;
      check_val("rst_out",   32'(out_code),  32'd0);
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_last",  32'(out_last),  32'd0);
      check_val("rst_ready", 32'(cmd_ready), 32'd1);
      check_val("rst_busy",  32'(busy),      32'd0);
      check_val("rst_done",  32'(done),      32'd0);
      check_val("rst_err",   32'(err),       32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 2: basic increment
      send_cmd(4'h0, 4'd5, 1'b1);
      check_val("t2_busy", 32'(busy), 32'd1);
      exp_q = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6};
      drain("t2");

      // 3: wrap on increment, then on decrement
      send_cmd(4'hE, 4'd3, 1'b1);
      exp_q = '{4'h9, 4'h8, 4'h0};
      drain("t3up");
      send_cmd(4'h1, 4'd3, 1'b0);
      exp_q = '{4'h1, 4'h0, 4'h8};
      drain("t3dn");

      // 4: backpressure holds the code stable
      send_cmd(4'h0, 4'd5, 1'b1);
      check_val("t4_first", 32'(out_code), 32'd0);
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_val("t4_hold_out",  32'(out_code),  32'd1);
         check_val("t4_hold_vld",  32'(out_valid), 32'd1);
         check_val("t4_hold_last", 32'(out_last),  32'd0);
         @(negedge clk);
      end
      exp_q = '{4'h1, 4'h3, 4'h2, 4'h6};
      drain("t4");

      // 5: abort on the second handshake; new command (with abort high in IDLE) accepted next
      send_cmd(4'h0, 4'd5, 1'b1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      check_val("t5_vld",  32'(out_valid), 32'd0);
      check_val("t5_rdy",  32'(cmd_ready), 32'd1);
      check_val("t5_done", 32'(done),      32'd0);
      check_val("t5_busy", 32'(busy),      32'd0);
      check_val("t5_last", 32'(out_last),  32'd0);
      send_cmd(4'h3, 4'd1, 1'b1);
      abort = 1'b0;
      exp_q = '{4'h2};
      drain("t5new");

      // abort on a final handshake suppresses done
      send_cmd(4'h7, 4'd1, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("t5f_done", 32'(done),      32'd0);
      check_val("t5f_vld",  32'(out_valid), 32'd0);
      check_val("t5f_rdy",  32'(cmd_ready), 32'd1);

      // 6: count 0 means a full lap of 16 codes
      send_cmd(4'h5, 4'd0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         logic [3:0] b;
         b = 4'(4'h5 + 4'(i));
         exp_q.push_back(b ^ (b >> 1));
      end
      drain("t6");
      check_val("t6_err", 32'(err), 32'd0);

      // reset mid-sequence clears outputs asynchronously
      send_cmd(4'h0, 4'd5, 1'b1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_val("mrst_out",  32'(out_code),  32'd0);
      check_val("mrst_vld",  32'(out_valid), 32'd0);
      check_val("mrst_busy", 32'(busy),      32'd0);
      check_val("mrst_rdy",  32'(cmd_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("mrst_idle_vld", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
